// File: rtl/dsp_arb_pkg.sv
// dsp_arb_pkg: shared widths, FSM state type and beat-count helper for the DMA write arbiter
package dsp_arb_pkg;

    localparam int CMD_W  = 64;
    localparam int DATA_W = 128;
    localparam int BTT_W  = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Number of 16-byte beats needed to move btt bytes, rounded up.
    function automatic logic [31:0] beat_count(input logic [31:0] btt);
        return (btt + 32'd15) >> 4;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at the channel after ptr
module rr_arbiter #(
    parameter int NCH = 3,
    parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] gnt
);

    // walk from furthest to nearest so the nearest requester after ptr wins
    always_comb begin
        gnt = '0;
        for (int k = NCH; k >= 1; k--)
            if (req[(int'(ptr) + k) % NCH])
                gnt = NCH'(1) << ((int'(ptr) + k) % NCH);
    end

endmodule

// File: rtl/dma_wr_arbiter.sv
// dma_wr_arbiter: round-robin muxing of per-channel command/data writers onto one shared FIFO pair
module dma_wr_arbiter #(
    parameter int NCH    = 3,
    parameter int CMD_W  = dsp_arb_pkg::CMD_W,
    parameter int DATA_W = dsp_arb_pkg::DATA_W,
    parameter int BTT_W  = dsp_arb_pkg::BTT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        req_i,
    input  logic [NCH*CMD_W-1:0]  cmd_din_i,
    input  logic [NCH-1:0]        cmd_wr_en_i,
    output logic [NCH-1:0]        cmd_full_o,
    input  logic [NCH*DATA_W-1:0] wr_din_i,
    input  logic [NCH-1:0]        wr_wr_en_i,
    output logic [NCH-1:0]        wr_full_o,
    output logic [CMD_W-1:0]      cmd_din_o,
    output logic                  cmd_wr_en_o,
    input  logic                  cmd_full_i,
    output logic [DATA_W-1:0]     wr_din_o,
    output logic                  wr_wr_en_o,
    input  logic                  wr_full_i,
    output logic [NCH-1:0]        grant_o,
    output logic                  busy_o,
    output logic                  proto_err_o
);

    import dsp_arb_pkg::*;

    localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = BTT_W - 3;

    state_t             state, state_nxt;
    logic [NCH-1:0]     grant, arb_gnt;
    logic [PW-1:0]      ptr, gidx;
    logic [CNT_W-1:0]   cnt, cmd_beats;
    logic [CMD_W-1:0]   cmd_sel;
    logic [DATA_W-1:0]  wr_sel;
    logic               cmd_acc, wr_acc, perr;

    rr_arbiter #(.NCH(NCH), .PW(PW)) u_rr (
        .req (req_i),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // AND-OR select of the granted channel's words and its index
    always_comb begin
        cmd_sel = '0;
        wr_sel  = '0;
        gidx    = '0;
        for (int i = 0; i < NCH; i++)
            if (grant[i]) begin
                cmd_sel = cmd_din_i[i*CMD_W +: CMD_W];
                wr_sel  = wr_din_i[i*DATA_W +: DATA_W];
                gidx    = PW'(i);
            end
    end

    assign cmd_acc   = (state == CMD)  && |(cmd_wr_en_i & grant) && !cmd_full_i;
    assign wr_acc    = (state == DATA) && |(wr_wr_en_i & grant)  && !wr_full_i;
    assign cmd_beats = CNT_W'(beat_count(32'(cmd_sel[BTT_W-1:0])));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: one burst is a command followed by its beats
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = |req_i ? CMD : IDLE;
            CMD:     state_nxt = !cmd_acc ? CMD : (cmd_beats == '0) ? IDLE : DATA;
            DATA:    state_nxt = (wr_acc && cnt == CNT_W'(1)) ? IDLE : DATA;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: only the granted channel on the active port sees the real full
    always_comb begin
        busy_o      = state != IDLE;
        grant_o     = grant;
        proto_err_o = perr;
        cmd_din_o   = cmd_sel;
        wr_din_o    = wr_sel;
        cmd_wr_en_o = cmd_acc;
        wr_wr_en_o  = wr_acc;
        cmd_full_o  = (state == CMD)  ? (~grant | {NCH{cmd_full_i}}) : '1;
        wr_full_o   = (state == DATA) ? (~grant | {NCH{wr_full_i}})  : '1;
    end

    // grant, round-robin pointer, beat counter and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant <= '0;
            ptr   <= PW'(NCH - 1);
            cnt   <= '0;
            perr  <= 1'b0;
        end else begin
            if (state == IDLE)
                grant <= arb_gnt;
            else if (state_nxt == IDLE) begin
                grant <= '0;
                ptr   <= gidx;
            end
            if (cmd_acc)
                cnt <= cmd_beats;
            else if (wr_acc)
                cnt <= cnt - CNT_W'(1);
            if (|((cmd_wr_en_i & cmd_full_o) | (wr_wr_en_i & wr_full_o)))
                perr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_wr_arbiter.sv
// tb_dma_wr_arbiter: directed and randomized bursts checked against a burst-level round-robin model
module tb_dma_wr_arbiter;

    localparam int NCH = 3;
    localparam int CW  = 64;
    localparam int DW  = 128;
    localparam int BW  = 23;
    localparam logic [NCH-1:0] ALL = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]    req = '0, cmd_wr_en = '0, wr_wr_en = '0;
    logic [NCH*CW-1:0] cmd_din = '0;
    logic [NCH*DW-1:0] wr_din = '0;
    logic              cmd_full_i = 1'b0, wr_full_i = 1'b0;
    logic [NCH-1:0]    cmd_full_o, wr_full_o, grant;
    logic [CW-1:0]     cmd_dout;
    logic [DW-1:0]     wr_dout;
    logic              cmd_we_o, wr_we_o, busy, perr;

    int   total = 0;
    int   bad = 0;
    int   last = NCH - 1;
    logic exp_perr = 1'b0;

    dma_wr_arbiter #(.NCH(NCH), .CMD_W(CW), .DATA_W(DW), .BTT_W(BW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .cmd_din_i   (cmd_din),
        .cmd_wr_en_i (cmd_wr_en),
        .cmd_full_o  (cmd_full_o),
        .wr_din_i    (wr_din),
        .wr_wr_en_i  (wr_wr_en),
        .wr_full_o   (wr_full_o),
        .cmd_din_o   (cmd_dout),
        .cmd_wr_en_o (cmd_we_o),
        .cmd_full_i  (cmd_full_i),
        .wr_din_o    (wr_dout),
        .wr_wr_en_o  (wr_we_o),
        .wr_full_i   (wr_full_i),
        .grant_o     (grant),
        .busy_o      (busy),
        .proto_err_o (perr)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NCH-1:0] m);
        for (int k = 1; k <= NCH; k++)
            if (m[(last + k) % NCH]) return (last + k) % NCH;
        return 0;
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, "_grant"}, grant, '0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_perr"}, perr, 0);
        chk({tag, "_cmd_full"}, cmd_full_o, ALL);
        chk({tag, "_wr_full"}, wr_full_o, ALL);
        chk({tag, "_cmd_we"}, cmd_we_o, 0);
        chk({tag, "_wr_we"}, wr_we_o, 0);
    endtask

    // Entered just after a negedge with the DUT idle; leaves at the idle cycle after the burst.
    task automatic do_burst(input logic [NCH-1:0] mask, input int btt, input int bp_pct,
                            input int fixed_stall, input int inj);
        int g, nb, sent, st, fulls_seen, beats_out;
        logic [NCH-1:0] oh, exp_f;
        logic [CW-1:0]  word;
        logic [DW-1:0]  d;
        logic           full, injected;
        req = mask;
        @(negedge clk);
        g = pick(mask);
        oh = '0;
        oh[g] = 1'b1;
        #1;
        chk("grant", grant, oh);
        chk("busy_cmd", busy, 1);
        repeat ($urandom_range(0, 2)) begin
            cmd_full_i = 1'b1;
            #1;
            chk("cmd_full_hold", cmd_full_o, ALL);
            chk("cmd_we_hold", cmd_we_o, 0);
            @(negedge clk);
        end
        cmd_full_i = 1'b0;
        word = {$urandom, $urandom};
        word[BW-1:0] = BW'(btt);
        cmd_din[g*CW +: CW] = word;
        cmd_wr_en[g] = 1'b1;
        #1;
        exp_f = ~oh;
        chk("cmd_we", cmd_we_o, 1);
        chk("cmd_din", cmd_dout, word);
        chk("cmd_full", cmd_full_o, exp_f);
        chk("wr_full_in_cmd", wr_full_o, ALL);
        chk("wr_we_in_cmd", wr_we_o, 0);
        @(negedge clk);
        cmd_wr_en = '0;
        if ($urandom_range(0, 1) == 1) req = '0;
        nb = (btt + 15) / 16;
        sent = 0;
        st = 0;
        fulls_seen = 0;
        beats_out = 0;
        injected = 1'b0;
        while (sent < nb) begin
            full = (fixed_stall > 0) ? (sent == 1 && st < fixed_stall)
                                     : ($urandom_range(0, 99) < bp_pct);
            if (full) st++;
            wr_full_i = full;
            d = {$urandom, $urandom, $urandom, $urandom};
            wr_din[g*DW +: DW] = d;
            wr_wr_en = '0;
            wr_wr_en[g] = !full;
            if (inj >= 0 && !injected) begin
                wr_wr_en[inj] = 1'b1;
                wr_din[inj*DW +: DW] = ~d;
                injected = 1'b1;
                exp_perr = 1'b1;
            end
            #1;
            exp_f = full ? ALL : ~oh;
            chk("wr_full", wr_full_o, exp_f);
            chk("wr_we", wr_we_o, !full);
            if (!full) chk("wr_din", wr_dout, d);
            chk("cmd_full_in_data", cmd_full_o, ALL);
            chk("cmd_we_in_data", cmd_we_o, 0);
            chk("busy_data", busy, 1);
            if (wr_full_o[g]) fulls_seen++;
            if (wr_we_o) beats_out++;
            if (!full) sent++;
            @(negedge clk);
        end
        wr_wr_en = '0;
        wr_full_i = 1'b0;
        req = '0;
        #1;
        chk("busy_end", busy, 0);
        chk("grant_end", grant, '0);
        chk("perr", perr, exp_perr);
        if (nb > 0) chk("beats", beats_out, nb);
        if (fixed_stall > 0) chk("stall_cycles", fulls_seen, fixed_stall);
        last = g;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk_rst("reset");
        @(negedge clk);
        rst_n = 1'b1;
        // all channels requesting from reset: expect 0,1,2,0
        repeat (4) do_burst(3'b111, $urandom_range(1, 64), 0, 0, -1);
        // ch1 alone, 64 bytes = 4 beats
        do_burst(3'b010, 64, 0, 0, -1);
        // zero-length command
        do_burst(3'b010, 0, 0, 0, -1);
        // ch0 32 bytes with 5-cycle back-pressure after first beat
        do_burst(3'b001, 32, 0, 5, -1);
        // ch2 strobes data while ch0 owns the port
        do_burst(3'b001, 48, 0, 0, 2);
        // randomized traffic
        repeat (25) do_burst(NCH'($urandom_range(1, 7)), $urandom_range(0, 120), 30, 0, -1);
        // reset during beat 2 of a ch1 burst that follows a ch0 burst
        do_burst(3'b001, 16, 0, 0, -1);
        req = 3'b010;
        @(negedge clk);
        #1;
        chk("abort_grant", grant, 3'b010);
        cmd_din[1*CW +: CW] = 64'd64;
        cmd_wr_en[1] = 1'b1;
        @(negedge clk);
        cmd_wr_en = '0;
        wr_wr_en[1] = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_beat2_we", wr_we_o, 1);
        rst_n = 1'b0;
        #1;
        chk_rst("abort_reset");
        exp_perr = 1'b0;
        last = NCH - 1;
        @(negedge clk);
        wr_wr_en = '0;
        req = '0;
        rst_n = 1'b1;
        do_burst(3'b111, 32, 0, 0, -1);
        chk("after_reset_ch0", last, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
